axis_seq_checker: RTL and testbench
===================================

Name: axis_seq_checker

Overview:
- AXI-Stream sink placed directly downstream of the power-of-3 stream generator.
- Accepts beats on an s00 slave port and buffers them in a small FIFO.
- Forwards buffered beats unchanged on an m00 master port.
- Checks every accepted beat against the expected 3^n sequence (modulo 2^DATA_WIDTH) and reports match/error statistics.

Parameters:
- DATA_WIDTH, 32, width of tdata on both ports; tstrb width is DATA_WIDTH/8.
- FIFO_DEPTH, 4, buffer entries; must be a power of 2 and at least 2.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- s00_axis_aclk  in  1  single clock for the whole block, both ports.
- s00_axis_aresetn  in  1  asynchronous active-low reset.
- s00_axis_tdata  in  DATA_WIDTH  input beat data.
- s00_axis_tstrb  in  DATA_WIDTH/8  input strobe; passed through, not checked.
- s00_axis_tvalid  in  1  input beat valid.
- s00_axis_tlast  in  1  input last flag; passed through.
- s00_axis_tready  out  1  block can accept a beat.
- m00_axis_tdata  out  DATA_WIDTH  forwarded data.
- m00_axis_tstrb  out  DATA_WIDTH/8  forwarded strobe.
- m00_axis_tvalid  out  1  forwarded beat valid.
- m00_axis_tlast  out  1  forwarded last flag.
- m00_axis_tready  in  1  downstream accepts a beat.
- clr_stats  in  1  synchronous clear of checker state and statistics.
- match_count  out  CNT_WIDTH  beats that matched the expected value.
- error_count  out  CNT_WIDTH  mismatched beats.
- seq_error  out  1  sticky flag, set on the first mismatch.
- first_err_data  out  DATA_WIDTH  tdata of the first mismatching beat.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, aresetn low): everything below takes effect immediately, no clock edge needed.
  - FIFO is emptied; fifo_level=0.
  - s00_axis_tready=0, m00_axis_tvalid=0.
  - m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast read as 0.
  - match_count=0, error_count=0, seq_error=0, first_err_data=0.
  - State=SYNC, expected=1.
- s00_axis_tready is registered:
  - Held 0 during reset.
  - From the first edge after reset release, each edge sets it to (next fifo_level < FIFO_DEPTH).
- Accept: s00_axis_tvalid && s00_axis_tready on a rising edge.
  - Pushes {tdata, tstrb, tlast} into the FIFO.
- Output side:
  - m00_axis_tvalid = (fifo_level != 0).
  - m00 data, strb and last come from the head entry.
  - A pop happens when m00_axis_tvalid && m00_axis_tready.
- Latency: a beat accepted at edge k is presented on m00 after edge k. There is no combinational bypass.
- Push and pop on the same edge: fifo_level is unchanged and order is preserved.
- Pointers wrap modulo FIFO_DEPTH.
- m00 outputs stay stable while m00_axis_tvalid=1 and m00_axis_tready=0.
- Checker FSM advances only on accepted beats. D is the accepted tdata.
  - SYNC:
    - D==1: match_count++, expected=3, go to TRACK.
    - Otherwise: no count change, stay in SYNC.
  - TRACK:
    - D==expected: match_count++, expected = expected*3 truncated to DATA_WIDTH, computed as (e<<1)+e.
    - Otherwise: error_count++, seq_error=1, go to FAULT. If seq_error was 0, first_err_data=D.
  - FAULT:
    - D==1: match_count++, expected=3, go to TRACK.
    - Otherwise: error_count++, stay in FAULT.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- clr_stats=1 at an edge:
  - Clears match_count, error_count, seq_error and first_err_data; sets State=SYNC, expected=1.
  - Takes priority over a simultaneous accepted beat: that beat is still pushed into the FIFO but is not checked.
  - Does not affect FIFO contents.
- Wrap-around: expected continues modulo 2^DATA_WIDTH, so long runs keep matching a truncating generator.
- Reset mid-operation: buffered beats are discarded and nothing is emitted on m00 afterwards.

Test Plan:
- Back-to-back accepted beats 1,3,9,27, m00_axis_tready=1 -> match_count=4, error_count=0, seq_error=0; m00 emits 1,3,9,27 in order, each one edge after acceptance.
- Beats 1,3,10,27,1,3 -> error_count=2, first_err_data=10, seq_error=1, match_count=4; state is FAULT after 27, TRACK after the second 1.
- m00_axis_tready=0, 5 beats offered with s00_axis_tvalid held -> 4 accepted; fifo_level=4; s00_axis_tready=0 from the edge after the 4th accept. Raise m00_axis_tready -> m00 drains 1,3,9,27, then the 5th beat (81) is accepted and forwarded.
- 22-beat run starting at 1, DATA_WIDTH=32 -> beat 21 is 3486784401 and matches; beat 22 is 1870418611 (3^21 mod 2^32) and matches; error_count=0, match_count=22.
- With fifo_level=3 and seq_error=1, pulse aresetn low between edges -> immediately fifo_level=0, m00_axis_tvalid=0, s00_axis_tready=0, counters=0. After release: s00_axis_tready=1 from the first edge, and a subsequent beat 1 gives match_count=1.
- clr_stats=1 on the same edge as an accepted beat 5, with error_count=3 -> counters=0, state=SYNC, and beat 5 still appears on m00.

Source files
------------

// File: rtl/axis_seq_checker_if.sv
// AXI-Stream bundle shared by the sequence checker's s00 and m00 ports.
// The master drives payload and valid; the slave drives ready.
interface axis_seq_checker_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic                    tvalid;
   logic                    tlast;
   logic                    tready;

   modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_seq_checker.sv
// AXI-Stream sink that buffers beats in a small FIFO, forwards them unchanged,
// and checks every accepted beat against the 3^n sequence (mod 2^DATA_WIDTH).
module axis_seq_checker #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        s00_axis_aclk,
   input  logic                        s00_axis_aresetn,
   axis_seq_checker_if.slave           s00_axis,
   axis_seq_checker_if.master          m00_axis,
   input  logic                        clr_stats,
   output logic [CNT_WIDTH-1:0]        match_count,
   output logic [CNT_WIDTH-1:0]        error_count,
   output logic                        seq_error,
   output logic [DATA_WIDTH-1:0]       first_err_data,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int SW = DATA_WIDTH / 8;
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [SW-1:0]         strb;
      logic                  last;
   } entry_t;

   typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

   entry_t                mem_q [FIFO_DEPTH];
   entry_t                mem_d [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  tready_q, tready_d;
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d;
   logic [CNT_WIDTH-1:0]  match_q, match_d, err_q, err_d;
   logic                  seq_err_q, seq_err_d;
   logic [DATA_WIDTH-1:0] first_q, first_d;
   logic                  push, pop;
   logic [DATA_WIDTH-1:0] beat;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign push = s00_axis.tvalid && tready_q;
   assign pop  = (level_q != '0) && m00_axis.tready;
   assign beat = s00_axis.tdata;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{data: s00_axis.tdata, strb: s00_axis.tstrb, last: s00_axis.tlast};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
      tready_d = (level_d < DEPTH_L);
   end

   // A clear wins over a beat accepted on the same edge; that beat is buffered but never checked.
   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      match_d   = match_q;
      err_d     = err_q;
      seq_err_d = seq_err_q;
      first_d   = first_q;
      if (clr_stats) begin
         state_d   = SYNC;
         exp_d     = DATA_WIDTH'(1);
         match_d   = '0;
         err_d     = '0;
         seq_err_d = 1'b0;
         first_d   = '0;
      end else if (push) begin
         case (state_q)
            SYNC, FAULT: begin
               if (beat == DATA_WIDTH'(1)) begin
                  match_d = sat_inc(match_q);
                  exp_d   = DATA_WIDTH'(3);
                  state_d = TRACK;
               end else if (state_q == FAULT) begin
                  err_d = sat_inc(err_q);
               end
            end
            TRACK: begin
               if (beat == exp_q) begin
                  match_d = sat_inc(match_q);
                  exp_d   = (exp_q << 1) + exp_q;
               end else begin
                  err_d     = sat_inc(err_q);
                  seq_err_d = 1'b1;
                  state_d   = FAULT;
                  if (!seq_err_q) begin
                     first_d = beat;
                  end
               end
            end
            default: state_d = SYNC;
         endcase
      end
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         tready_q  <= 1'b0;
         state_q   <= SYNC;
         exp_q     <= DATA_WIDTH'(1);
         match_q   <= '0;
         err_q     <= '0;
         seq_err_q <= 1'b0;
         first_q   <= '0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         tready_q  <= tready_d;
         state_q   <= state_d;
         exp_q     <= exp_d;
         match_q   <= match_d;
         err_q     <= err_d;
         seq_err_q <= seq_err_d;
         first_q   <= first_d;
      end
   end

   assign s00_axis.tready = tready_q;
   assign m00_axis.tvalid = (level_q != '0);
   assign m00_axis.tdata  = mem_q[rd_ptr_q].data;
   assign m00_axis.tstrb  = mem_q[rd_ptr_q].strb;
   assign m00_axis.tlast  = mem_q[rd_ptr_q].last;
   assign match_count     = match_q;
   assign error_count     = err_q;
   assign seq_error       = seq_err_q;
   assign first_err_data  = first_q;
   assign fifo_level      = level_q;
endmodule

// File: tb/tb_axis_seq_checker.sv
// Directed bench for axis_seq_checker: forwarding, sequence checking,
// backpressure, wrap-around, async reset and clear/accept collision.
module tb_axis_seq_checker;
   localparam int DW = 32;
   localparam int DEPTH = 4;
   localparam int CW = 16;
   localparam int LW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr_stats;
   logic [CW-1:0] match_count, error_count;
   logic seq_error;
   logic [DW-1:0] first_err_data;
   logic [LW-1:0] fifo_level;

   int vectors = 0;
   int miscompares = 0;
   logic [DW-1:0] out_q [$];

   axis_seq_checker_if #(.DATA_WIDTH(DW)) s_if ();
   axis_seq_checker_if #(.DATA_WIDTH(DW)) m_if ();

   axis_seq_checker #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .s00_axis_aclk(clk),
      .s00_axis_aresetn(rst_n),
      .s00_axis(s_if),
      .m00_axis(m_if),
      .clr_stats(clr_stats),
      .match_count(match_count),
      .error_count(error_count),
      .seq_error(seq_error),
      .first_err_data(first_err_data),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   // Inputs change only 1 time unit after a rising edge, so a handshake seen here pops on the next edge.
   always @(negedge clk) begin
      if (rst_n && m_if.tvalid && m_if.tready) out_q.push_back(m_if.tdata);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic last);
      int waited;
      waited = 0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tstrb  = 4'hF;
      s_if.tlast  = last;
      while (!s_if.tready && waited < 50) begin
         step();
         waited++;
      end
      if (!s_if.tready) begin
         vectors++; miscompares++;
         $display("[TB] FAIL send_timeout: tready got 0 required 1 for beat %0d", d);
      end else begin
         step();
      end
      s_if.tvalid = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (m_if.tvalid && waited < 50) begin
         step();
         waited++;
      end
      vectors++;
      if (m_if.tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_timeout: m_tvalid got %0b required 0", m_if.tvalid); end
   endtask

   task automatic clear_stats();
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      vectors++; if (s_if.tready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_s_tready: got %0b required 0", s_if.tready); end
      vectors++; if (m_if.tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_m_tvalid: got %0b required 0", m_if.tvalid); end
      vectors++; if (m_if.tdata !== 32'd0 || m_if.tstrb !== 4'd0 || m_if.tlast !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_m_payload: got %0h/%0h/%0b required 0", m_if.tdata, m_if.tstrb, m_if.tlast); end
      vectors++; if (match_count !== 16'd0 || error_count !== 16'd0) begin miscompares++; $display("[TB] FAIL rst_counts: got %0d/%0d required 0/0", match_count, error_count); end
      vectors++; if (seq_error !== 1'b0 || first_err_data !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_err: got %0b/%0d required 0/0", seq_error, first_err_data); end
      vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_level: got %0d required 0", fifo_level); end
      step();
      rst_n = 1'b1;
      step();
      vectors++; if (s_if.tready !== 1'b1) begin miscompares++; $display("[TB] FAIL rel_s_tready: got %0b required 1", s_if.tready); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] vals [4];
      vals = '{32'd1, 32'd3, 32'd9, 32'd27};
      out_q.delete();
      m_if.tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(vals[i], i == 3);
         vectors++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== vals[i]) begin miscompares++; $display("[TB] FAIL b2b_latency[%0d]: got v=%0b d=%0d required v=1 d=%0d", i, m_if.tvalid, m_if.tdata, vals[i]); end
      end
      vectors++; if (m_if.tlast !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_tlast: got %0b required 1", m_if.tlast); end
      drain();
      vectors++; if (match_count !== 16'd4 || error_count !== 16'd0 || seq_error !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_stats: got m=%0d e=%0d s=%0b required 4/0/0", match_count, error_count, seq_error); end
      vectors++; if (out_q.size() != 4) begin miscompares++; $display("[TB] FAIL b2b_out_count: got %0d required 4", out_q.size()); end
      else for (int i = 0; i < 4; i++) begin
         vectors++; if (out_q[i] !== vals[i]) begin miscompares++; $display("[TB] FAIL b2b_order[%0d]: got %0d required %0d", i, out_q[i], vals[i]); end
      end
   endtask

   task automatic test_error_sequence();
      logic [DW-1:0] vals [6];
      logic [CW-1:0] exp_m [6];
      logic [CW-1:0] exp_e [6];
      vals  = '{32'd1, 32'd3, 32'd10, 32'd27, 32'd1, 32'd3};
      exp_m = '{16'd1, 16'd2, 16'd2, 16'd2, 16'd3, 16'd4};
      exp_e = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd2, 16'd2};
      clear_stats();
      out_q.delete();
      for (int i = 0; i < 6; i++) begin
         send(vals[i], 1'b0);
         vectors++; if (match_count !== exp_m[i] || error_count !== exp_e[i]) begin miscompares++; $display("[TB] FAIL err_counts[%0d]: got m=%0d e=%0d required m=%0d e=%0d", i, match_count, error_count, exp_m[i], exp_e[i]); end
      end
      vectors++; if (seq_error !== 1'b1 || first_err_data !== 32'd10) begin miscompares++; $display("[TB] FAIL err_first: got s=%0b d=%0d required s=1 d=10", seq_error, first_err_data); end
      drain();
      vectors++; if (out_q.size() != 6) begin miscompares++; $display("[TB] FAIL err_out_count: got %0d required 6", out_q.size()); end
      else for (int i = 0; i < 6; i++) begin
         vectors++; if (out_q[i] !== vals[i]) begin miscompares++; $display("[TB] FAIL err_order[%0d]: got %0d required %0d", i, out_q[i], vals[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] vals [5];
      vals = '{32'd1, 32'd3, 32'd9, 32'd27, 32'd81};
      clear_stats();
      out_q.delete();
      m_if.tready = 1'b0;
      for (int i = 0; i < 4; i++) send(vals[i], 1'b0);
      vectors++; if (s_if.tready !== 1'b0 || fifo_level !== 3'd4) begin miscompares++; $display("[TB] FAIL bp_full: got rdy=%0b lvl=%0d required rdy=0 lvl=4", s_if.tready, fifo_level); end
      s_if.tvalid = 1'b1;
      s_if.tdata  = vals[4];
      step();
      step();
      vectors++; if (fifo_level !== 3'd4 || m_if.tvalid !== 1'b1 || m_if.tdata !== 32'd1) begin miscompares++; $display("[TB] FAIL bp_stall: got lvl=%0d v=%0b d=%0d required 4/1/1", fifo_level, m_if.tvalid, m_if.tdata); end
      m_if.tready = 1'b1;
      send(vals[4], 1'b1);
      drain();
      vectors++; if (match_count !== 16'd5 || error_count !== 16'd0) begin miscompares++; $display("[TB] FAIL bp_stats: got m=%0d e=%0d required 5/0", match_count, error_count); end
      vectors++; if (out_q.size() != 5) begin miscompares++; $display("[TB] FAIL bp_out_count: got %0d required 5", out_q.size()); end
      else for (int i = 0; i < 5; i++) begin
         vectors++; if (out_q[i] !== vals[i]) begin miscompares++; $display("[TB] FAIL bp_order[%0d]: got %0d required %0d", i, out_q[i], vals[i]); end
      end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] e;
      clear_stats();
      m_if.tready = 1'b1;
      e = 32'd1;
      for (int i = 0; i < 22; i++) begin
         send(e, i == 21);
         if (m_if.tdata !== e) begin vectors++; miscompares++; $display("[TB] FAIL wrap_data[%0d]: got %0d required %0d", i, m_if.tdata, e); end
         e = e * 32'd3;
      end
      vectors++;
      vectors++; if (m_if.tdata !== 32'd1870418611) begin miscompares++; $display("[TB] FAIL wrap_beat22: got %0d required 1870418611", m_if.tdata); end
      vectors++; if (match_count !== 16'd22 || error_count !== 16'd0) begin miscompares++; $display("[TB] FAIL wrap_stats: got m=%0d e=%0d required 22/0", match_count, error_count); end
      drain();
   endtask

   task automatic test_reset_mid();
      clear_stats();
      m_if.tready = 1'b0;
      send(32'd1, 1'b0);
      send(32'd5, 1'b0);
      send(32'd7, 1'b0);
      vectors++; if (fifo_level !== 3'd3 || seq_error !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_setup: got lvl=%0d s=%0b required 3/1", fifo_level, seq_error); end
      #3;
      rst_n = 1'b0;
      #1;
      vectors++; if (fifo_level !== 3'd0 || m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_async: got lvl=%0d v=%0b rdy=%0b required 0/0/0", fifo_level, m_if.tvalid, s_if.tready); end
      vectors++; if (match_count !== 16'd0 || error_count !== 16'd0 || seq_error !== 1'b0 || first_err_data !== 32'd0) begin miscompares++; $display("[TB] FAIL mid_stats: got m=%0d e=%0d s=%0b f=%0d required 0", match_count, error_count, seq_error, first_err_data); end
      #2;
      rst_n = 1'b1;
      out_q.delete();
      m_if.tready = 1'b1;
      step();
      vectors++; if (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_release: got rdy=%0b v=%0b required 1/0", s_if.tready, m_if.tvalid); end
      send(32'd1, 1'b0);
      drain();
      vectors++; if (match_count !== 16'd1) begin miscompares++; $display("[TB] FAIL mid_match: got %0d required 1", match_count); end
      vectors++; if (out_q.size() != 1 || out_q[0] !== 32'd1) begin miscompares++; $display("[TB] FAIL mid_out: got %0d beats required only beat 1", out_q.size()); end
   endtask

   task automatic test_clr_collision();
      for (int i = 0; i < 3; i++) send(32'd2, 1'b0);
      vectors++; if (error_count !== 16'd3) begin miscompares++; $display("[TB] FAIL clr_setup: got e=%0d required 3", error_count); end
      clr_stats = 1'b1;
      send(32'd5, 1'b0);
      clr_stats = 1'b0;
      vectors++; if (match_count !== 16'd0 || error_count !== 16'd0 || seq_error !== 1'b0 || first_err_data !== 32'd0) begin miscompares++; $display("[TB] FAIL clr_stats: got m=%0d e=%0d s=%0b f=%0d required 0", match_count, error_count, seq_error, first_err_data); end
      vectors++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'd5) begin miscompares++; $display("[TB] FAIL clr_forward: got v=%0b d=%0d required 1/5", m_if.tvalid, m_if.tdata); end
      send(32'd3, 1'b0);
      vectors++; if (match_count !== 16'd0 || error_count !== 16'd0) begin miscompares++; $display("[TB] FAIL clr_sync: got m=%0d e=%0d required 0/0", match_count, error_count); end
      send(32'd1, 1'b0);
      vectors++; if (match_count !== 16'd1) begin miscompares++; $display("[TB] FAIL clr_resync: got %0d required 1", match_count); end
      drain();
   endtask

   initial begin
      clr_stats   = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tstrb  = '0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b0;
      test_reset();
      test_back_to_back();
      test_error_sequence();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      test_clr_collision();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
